// File: rtl/rp_scope_calib_pkg.sv
// rtl/rp_scope_calib_pkg.sv - shared FSM encoding, limits and widths for the scope offset calibration sequencer
package rp_scope_calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_CALC,
    ST_COMMIT
  } calib_state_t;

  localparam logic [15:0] GAIN_UNITY = 16'h8000;

  // 15 headroom bits hold the sum of up to 2**15 full-scale samples
  localparam int ACC_EXTRA = 15;

  function automatic int acc_w(input int dbits);
    return dbits + ACC_EXTRA;
  endfunction

  function automatic longint calc_max(input int dbits);
    return (longint'(1) << (dbits - 1)) - 1;
  endfunction

  function automatic longint calc_min(input int dbits);
    return -(longint'(1) << (dbits - 1));
  endfunction

endpackage

// File: rtl/rp_scope_calib_acc.sv
// rtl/rp_scope_calib_acc.sv - sample counter and signed accumulator; last flags the 2**n-th accepted sample
module rp_scope_calib_acc #(
  parameter int DBITS = 16,
  parameter int ACC_W = 31
) (
  input  logic                    adc_clk_i,
  input  logic                    adc_rst_i,
  input  logic                    clr,
  input  logic                    en,
  input  logic [3:0]              n,
  input  logic signed [DBITS-1:0] din,
  output logic signed [ACC_W-1:0] acc,
  output logic                    last
);

  logic [15:0] cnt;

  assign last = en && (cnt == ((16'd1 << n) - 16'd1));

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(din);
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/rp_scope_calib_ctrl.sv
// rtl/rp_scope_calib_ctrl.sv - auto-offset calibration sequencer for one scope channel
// Optional no-valid timeout in ACCUM: define SCOPE_CALIB_CTRL_TIMEOUT_EN.
module rp_scope_calib_ctrl
  import rp_scope_calib_pkg::*;
#(
  parameter int DBITS   = 16,
  parameter int SET_W   = 16,
  parameter int TMO_CYC = 65535
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [3:0]       cfg_avg_log2_i,
  input  logic [SET_W-1:0] cfg_settle_i,
  input  logic [DBITS-1:0] cfg_target_i,
  input  logic [DBITS-1:0] sw_offset_i,
  input  logic             sw_offset_we_i,
  input  logic [15:0]      cfg_gain_i,
  input  logic [DBITS-1:0] mon_dat_i,
  input  logic             mon_tvalid_i,
  output logic [DBITS-1:0] calib_offset_o,
  output logic [15:0]      calib_gain_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sat_o,
  output logic             err_o,
  output logic [DBITS-1:0] meas_avg_o
);

  localparam int ACC_W = acc_w(DBITS);
  localparam int MW    = DBITS + 2;
  localparam logic signed [MW-1:0] MAX_V = MW'(calc_max(DBITS));
  localparam logic signed [MW-1:0] MIN_V = MW'(calc_min(DBITS));

  calib_state_t state;
  logic signed [DBITS-1:0] off_save, target_l, avg_r, new_r;
  logic [3:0]              n_l;
  logic [SET_W-1:0]        settle_l, settle_cnt;
  logic                    sat_r;

  logic signed [ACC_W-1:0] acc;
  logic                    acc_last, acc_en, acc_clr;
  logic signed [DBITS-1:0] avg_c;
  logic signed [MW-1:0]    diff_c, sum_c, new_c;
  logic                    sat_c;

  assign acc_en  = (state == ST_ACCUM) && mon_tvalid_i;
  assign acc_clr = (state == ST_IDLE);

  rp_scope_calib_acc #(.DBITS(DBITS), .ACC_W(ACC_W)) u_acc (
    .adc_clk_i (adc_clk_i),
    .adc_rst_i (adc_rst_i),
    .clr       (acc_clr),
    .en        (acc_en),
    .n         (n_l),
    .din       (mon_dat_i),
    .acc       (acc),
    .last      (acc_last)
  );

  // Floor average, then offset correction widened so the clamp sees true overflow
  assign avg_c  = DBITS'(acc >>> n_l);
  assign diff_c = MW'(target_l) - MW'(avg_c);
  assign sum_c  = MW'(off_save) + diff_c;
  assign sat_c  = (sum_c > MAX_V) || (sum_c < MIN_V);
  assign new_c  = (sum_c > MAX_V) ? MAX_V : (sum_c < MIN_V) ? MIN_V : sum_c;

`ifdef SCOPE_CALIB_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state          <= ST_IDLE;
      calib_offset_o <= '0;
      calib_gain_o   <= GAIN_UNITY;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      sat_o          <= 1'b0;
      meas_avg_o     <= '0;
      off_save       <= '0;
      target_l       <= '0;
      avg_r          <= '0;
      new_r          <= '0;
      sat_r          <= 1'b0;
      n_l            <= '0;
      settle_l       <= '0;
      settle_cnt     <= '0;
`ifdef SCOPE_CALIB_CTRL_TIMEOUT_EN
      err_o          <= 1'b0;
      tmo_cnt        <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (state == ST_IDLE) begin
        calib_gain_o <= cfg_gain_i;
        if (start_i) begin
          off_save   <= calib_offset_o;
          n_l        <= cfg_avg_log2_i;
          target_l   <= cfg_target_i;
          settle_l   <= cfg_settle_i;
          settle_cnt <= '0;
          sat_o      <= 1'b0;
          busy_o     <= 1'b1;
          state      <= ST_SETTLE;
`ifdef SCOPE_CALIB_CTRL_TIMEOUT_EN
          err_o      <= 1'b0;
          tmo_cnt    <= '0;
`endif
        end else if (sw_offset_we_i) begin
          calib_offset_o <= sw_offset_i;
        end
      end else if (abort_i) begin
        calib_offset_o <= off_save;
        busy_o         <= 1'b0;
        state          <= ST_IDLE;
      end else begin
        case (state)
          ST_SETTLE: begin
            if (settle_cnt == settle_l) state <= ST_ACCUM;
            else settle_cnt <= settle_cnt + 1'b1;
          end
          ST_ACCUM: begin
            if (acc_en && acc_last) state <= ST_CALC;
`ifdef SCOPE_CALIB_CTRL_TIMEOUT_EN
            if (mon_tvalid_i) begin
              tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
              err_o          <= 1'b1;
              calib_offset_o <= off_save;
              busy_o         <= 1'b0;
              state          <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          ST_CALC: begin
            avg_r <= avg_c;
            new_r <= DBITS'(new_c);
            sat_r <= sat_c;
            state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            calib_offset_o <= new_r;
            meas_avg_o     <= avg_r;
            sat_o          <= sat_r;
            done_o         <= 1'b1;
            busy_o         <= 1'b0;
            state          <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
